// File: rtl/encryption.sv
// rtl/encryption.sv - plaintext FIFO feeding a permute-then-XOR stage with rotating key K1,K2,K3
module encryption #(
  parameter int             N     = 8,
  parameter int             DEPTH = 4,
  parameter logic [N-1:0]   K1    = 8'b0011_1110,
  parameter logic [N-1:0]   K2    = 8'b0100_1001,
  parameter logic [N-1:0]   K3    = 8'b0111_1110
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N-1:0]             din,
  input  logic                     hold,
  input  logic                     sync,
  output logic                     en,
  output logic [N-1:0]             dout,
  output logic [1:0]               key_phase,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [N-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic [N-1:0]  head;
  logic [N-1:0]  perm;
  logic [N-1:0]  key;

  assign in_ready = !rst && (level < FULL);
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];

  // Inverse of the downstream decryption permutation.
  assign perm = {head[0], head[5], head[2], head[6], head[7], head[4], head[3], head[1]};

  // A sync on a pop cycle forces the popped byte onto K1.
  always_comb begin
    key = K1;
    if (!sync) begin
      case (key_phase)
        2'd1:    key = K2;
        2'd2:    key = K3;
        default: key = K1;
      endcase
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (level != '0) state_next = RUN;
      end
      RUN: begin
        if (hold) begin
          state_next = PAUSE;
        end else if (level == '0 || (level == (AW+1)'(1) && !push)) begin
          state_next = IDLE;
        end
      end
      PAUSE: begin
        if (!hold) state_next = (level != '0) ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pop = 1'b0;
    if (state == RUN && !hold && level != '0) pop = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      en        <= 1'b0;
      dout      <= '0;
      key_phase <= 2'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      en <= pop;
      if (pop) begin
        dout <= perm ^ key;
        if (sync) begin
          key_phase <= 2'd1;
        end else begin
          key_phase <= (key_phase == 2'd2) ? 2'd0 : key_phase + 2'd1;
        end
      end else if (sync) begin
        key_phase <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_encryption.sv
// tb/tb_encryption.sv - randomized and directed checks of encryption against a queue-based model
module tb_encryption;

  logic       clock = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] din;
  logic       hold;
  logic       sync;
  logic       en;
  logic [7:0] dout;
  logic [1:0] key_phase;
  logic [2:0] level;

  encryption dut (
    .clock     (clock),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .hold      (hold),
    .sync      (sync),
    .en        (en),
    .dout      (dout),
    .key_phase (key_phase),
    .level     (level)
  );

  always #5 clock = ~clock;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] q[$];
  int         mph = 0;
  logic [7:0] keys [3] = '{8'h3E, 8'h49, 8'h7E};
  // destination bit for each plaintext bit i
  int         dst [8] = '{7, 0, 5, 1, 2, 6, 4, 3};

  function automatic logic [7:0] permute(logic [7:0] p);
    logic [7:0] x;
    x = '0;
    for (int i = 0; i < 8; i++) x[dst[i]] = p[i];
    return x;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: sample handshake before the edge, update model and compare at the next negedge
  task automatic tick();
    logic       push_s;
    logic       sync_s;
    logic [7:0] din_s;
    logic [7:0] p;
    int         ph;
    push_s = in_valid && in_ready;
    sync_s = sync;
    din_s  = din;
    @(posedge clock);
    @(negedge clock);
    if (rst) begin
      q.delete();
      mph = 0;
      return;
    end
    if (en) begin
      if (q.size() == 0) begin
        check("stale_en", 32'(en), 32'd0);
      end else begin
        p  = q.pop_front();
        ph = sync_s ? 0 : mph;
        check("dout", 32'(dout), 32'(permute(p) ^ keys[ph]));
        mph = (ph + 1) % 3;
      end
    end else if (sync_s) begin
      mph = 0;
    end
    if (push_s) q.push_back(din_s);
    check("key_phase", 32'(key_phase), 32'(mph));
    check("level", 32'(level), 32'(q.size()));
    check("in_ready", 32'(in_ready), 32'(q.size() < 4));
  endtask

  task automatic drain(string tag);
    in_valid = 1'b0;
    hold     = 1'b0;
    sync     = 1'b0;
    for (int i = 0; i < 30 && (q.size() != 0 || en); i++) tick();
    tick();
    check(tag, 32'(q.size()), 32'd0);
  endtask

  task automatic wait_en(string tag, output logic [7:0] d);
    logic ok;
    ok = 1'b0;
    d  = '0;
    for (int i = 0; i < 12 && !ok; i++) begin
      tick();
      if (en) begin
        ok = 1'b1;
        d  = dout;
      end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  logic [7:0] vec [4] = '{8'h01, 8'h80, 8'hFF, 8'h00};
  logic [7:0] exp1 [4] = '{8'hBE, 8'h41, 8'h81, 8'h3E};
  logic       en_log [8];
  logic [7:0] dout_log [8];
  logic [7:0] d;
  int         acc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; din = '0; hold = 1'b0; sync = 1'b0;
    @(negedge clock);
    check("rst_en", 32'(en), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_key_phase", 32'(key_phase), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    tick();

    // back-to-back push of four known bytes: latency and K1,K2,K3,K1 rotation
    for (int k = 0; k < 8; k++) begin
      in_valid = (k < 4);
      din      = (k < 4) ? vec[k] : 8'h00;
      tick();
      en_log[k]   = en;
      dout_log[k] = dout;
    end
    check("t1_lat0", 32'(en_log[0]), 32'd0);
    check("t1_lat1", 32'(en_log[1]), 32'd0);
    for (int k = 0; k < 4; k++) begin
      check("t1_en", 32'(en_log[k+2]), 32'd1);
      check("t1_dout", 32'(dout_log[k+2]), 32'(exp1[k]));
    end
    check("t1_en_end", 32'(en_log[6]), 32'd0);
    drain("t1_drain");

    // random stream, random hold, no sync
    acc = 0;
    for (int i = 0; i < 300 && acc < 16; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      din      = 8'($urandom);
      hold     = ($urandom_range(0, 4) == 0);
      if (in_valid && in_ready) acc++;
      tick();
    end
    check("t2_accepted", 32'(acc), 32'd16);
    drain("t2_drain");

    // hold fills the FIFO; fifth byte waits for space
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      din      = 8'($urandom);
      tick();
    end
    din = 8'hA5;
    tick();
    tick();
    check("t3_level_full", 32'(level), 32'd4);
    check("t3_ready_full", 32'(in_ready), 32'd0);
    check("t3_en_held", 32'(en), 32'd0);
    hold = 1'b0;
    acc  = 0;
    for (int i = 0; i < 12 && acc < 1; i++) begin
      if (in_ready) acc++;
      tick();
    end
    check("t3_fifth_accepted", 32'(acc), 32'd1);
    drain("t3_drain");

    // sync in an idle cycle restarts at K1
    sync = 1'b1; tick(); sync = 1'b0;
    in_valid = 1'b1; din = 8'h00; tick(); in_valid = 1'b0;
    wait_en("t4_first_timeout", d);
    check("t4_first_k1", 32'(d), 32'h3E);
    tick();
    sync = 1'b1; tick(); sync = 1'b0;
    in_valid = 1'b1; din = 8'h00; tick(); in_valid = 1'b0;
    wait_en("t4_second_timeout", d);
    check("t4_second_k1", 32'(d), 32'h3E);
    drain("t4_drain");

    // sync coincident with a pop mid-stream
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; din = 8'h00; tick();
    end
    in_valid = 1'b0; hold = 1'b0;
    wait_en("t5_timeout", d);
    check("t5_first_k2", 32'(d), 32'h49);
    sync = 1'b1; tick(); sync = 1'b0;
    check("t5_sync_en", 32'(en), 32'd1);
    check("t5_sync_k1", 32'(dout), 32'h3E);
    tick();
    check("t5_next_en", 32'(en), 32'd1);
    check("t5_next_k2", 32'(dout), 32'h49);
    drain("t5_drain");

    // random stream with random hold and sync
    for (int i = 0; i < 80; i++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      din      = 8'($urandom);
      hold     = ($urandom_range(0, 5) == 0);
      sync     = ($urandom_range(0, 7) == 0);
      tick();
    end
    drain("t7_drain");

    // asynchronous reset mid-stream
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; din = 8'($urandom); tick();
    end
    in_valid = 1'b0; hold = 1'b0;
    wait_en("t6_timeout", d);
    check("t6_level_before", 32'(level), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("t6_en", 32'(en), 32'd0);
    check("t6_dout", 32'(dout), 32'd0);
    check("t6_level", 32'(level), 32'd0);
    check("t6_in_ready", 32'(in_ready), 32'd0);
    q.delete();
    mph = 0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("t6_no_stale", 32'(en), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
